// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
// State encoding, 4x4 hex code table and key-code width helper.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      HELD,
      RELEASE
   } state_t;

   localparam logic [3:0] HEX_TABLE [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   function automatic int key_width(input int rows, input int cols);
      int w;
      w = $clog2(rows * cols);
      return (w < 4) ? 4 : w;
   endfunction

   function automatic logic [3:0] hex_code(input int row, input int col);
      logic [1:0] r;
      logic [1:0] c;
      r = row[1:0];
      c = col[1:0];
      return HEX_TABLE[r][c];
   endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Resets to all-zero so no stale input survives reset.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row drive, column debounce and one
// registered key event per accepted press on a valid/ready port.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int SCAN_CYCLES     = 4,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int HEX_MAP         = 1
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic [COLS-1:0]                     i_cols,
   output logic [ROWS-1:0]                     o_rows,
   output logic                                o_key_valid,
   output logic [key_width(ROWS, COLS)-1:0]    o_key_code,
   input  logic                                i_key_ready,
   output logic                                o_key_held,
   output logic                                o_overflow
);

   localparam int KW = key_width(ROWS, COLS);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int SW = $clog2(SCAN_CYCLES);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

   localparam logic [RW-1:0]   ROW_LAST  = RW'(ROWS - 1);
   localparam logic [SW-1:0]   SLOT_LAST = SW'(SCAN_CYCLES - 1);
   localparam logic [DW-1:0]   DB_DONE   = DW'(DEBOUNCE_CYCLES);
   localparam logic [ROWS-1:0] ROW0      = ROWS'(1);
   localparam logic [COLS-1:0] COL0      = COLS'(1);

   state_t          r_state;
   state_t          w_state;
   logic [RW-1:0]   r_row;
   logic [RW-1:0]   w_row;
   logic [CW-1:0]   r_col;
   logic [CW-1:0]   w_col;
   logic [SW-1:0]   r_slot;
   logic [SW-1:0]   w_slot;
   logic [DW-1:0]   r_db;
   logic [DW-1:0]   w_db;
   logic [DW-1:0]   r_rel;
   logic [DW-1:0]   w_rel;
   logic [ROWS-1:0] r_rows;
   logic            r_valid;
   logic            w_valid;
   logic [KW-1:0]   r_code;
   logic [KW-1:0]   w_code_nxt;
   logic            r_ovf;
   logic            w_ovf;

   logic [COLS-1:0] w_cs;
   logic [COLS-1:0] w_col_oh;
   logic [CW-1:0]   w_hit_col;
   logic            w_one_hot;
   logic [RW-1:0]   w_row_adv;
   logic            w_accept;
   logic [KW-1:0]   w_code;

   generate
      if (HEX_MAP != 0) begin : g_hex
         if (ROWS != 4 || COLS != 4) begin : g_bad
            $error("HEX_MAP=1 requires a 4x4 keypad");
         end
         assign w_code = KW'(hex_code(int'(r_row), int'(r_col)));
      end else begin : g_raw
         assign w_code = KW'(r_row) * KW'(COLS) + KW'(r_col);
      end
   endgenerate

   sync_2ff #(
      .WIDTH (COLS)
   ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_cols),
      .o_q     (w_cs)
   );

   // Exactly-one-column test; the index is only used when it holds
   assign w_one_hot = (w_cs != '0) && ((w_cs & (w_cs - COL0)) == '0);
   assign w_col_oh  = COL0 << r_col;
   assign w_row_adv = (r_row == ROW_LAST) ? '0 : r_row + RW'(1);

   always_comb begin
      w_hit_col = '0;
      for (int i = 0; i < COLS; i++) begin
         if (w_cs[i]) w_hit_col = CW'(i);
      end
   end

   always_comb begin
      w_state  = r_state;
      w_row    = r_row;
      w_col    = r_col;
      w_slot   = r_slot;
      w_db     = r_db;
      w_rel    = r_rel;
      w_accept = 1'b0;
      unique case (r_state)
         SCAN: begin
            if (r_slot == SLOT_LAST) begin
               w_slot = '0;
               if (w_one_hot) begin
                  w_col   = w_hit_col;
                  w_db    = '0;
                  w_state = DEBOUNCE;
               end else begin
                  w_row = w_row_adv;
               end
            end else begin
               w_slot = r_slot + SW'(1);
            end
         end
         DEBOUNCE: begin
            if (r_db == DB_DONE) begin
               w_accept = 1'b1;
               w_rel    = '0;
               w_state  = HELD;
            end else if (w_cs == w_col_oh) begin
               w_db = r_db + DW'(1);
            end else begin
               w_slot  = '0;
               w_state = SCAN;
            end
         end
         HELD: begin
            if (r_rel == DB_DONE) begin
               w_state = RELEASE;
            end else if (!w_cs[r_col]) begin
               w_rel = r_rel + DW'(1);
            end else begin
               w_rel = '0;
            end
         end
         RELEASE: begin
            w_row   = w_row_adv;
            w_slot  = '0;
            w_state = SCAN;
         end
         default: w_state = SCAN;
      endcase
   end

   // A handshake in the accept clock frees the slot for the new event
   always_comb begin
      w_valid    = r_valid;
      w_code_nxt = r_code;
      w_ovf      = 1'b0;
      if (w_accept) begin
         if (!r_valid || i_key_ready) begin
            w_valid    = 1'b1;
            w_code_nxt = w_code;
         end else begin
            w_ovf = 1'b1;
         end
      end else if (r_valid && i_key_ready) begin
         w_valid = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= SCAN;
         r_row   <= '0;
         r_col   <= '0;
         r_slot  <= '0;
         r_db    <= '0;
         r_rel   <= '0;
         r_rows  <= ROW0;
         r_valid <= 1'b0;
         r_code  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state;
         r_row   <= w_row;
         r_col   <= w_col;
         r_slot  <= w_slot;
         r_db    <= w_db;
         r_rel   <= w_rel;
         r_rows  <= ROW0 << w_row;
         r_valid <= w_valid;
         r_code  <= w_code_nxt;
         r_ovf   <= w_ovf;
      end
   end

   assign o_rows      = r_rows;
   assign o_key_valid = r_valid;
   assign o_key_code  = r_code;
   assign o_key_held  = (r_state == HELD);
   assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomised bench for keypad_scanner: physical keypad model plus
// an edge-indexed timeline of expected events derived from scan arithmetic.
module tb_keypad_scanner;

   localparam int R  = 4;
   localparam int C  = 4;
   localparam int SC = 4;
   localparam int D  = 8;
   localparam int HEXT [16] = '{1, 2, 3, 10, 4, 5, 6, 11,
                                7, 8, 9, 12, 14, 0, 15, 13};

   logic       clk;
   logic       rst_n;
   logic [3:0] cols1;
   logic [3:0] rows1;
   logic       valid1;
   logic [3:0] code1;
   logic       ready1;
   logic       held1;
   logic       ovf1;
   logic [2:0] cols2;
   logic [1:0] rows2;
   logic       valid2;
   logic [3:0] code2;
   logic       ready2;
   logic       held2;
   logic       ovf2;

   logic [15:0] press1;
   logic [5:0]  press2;

   int n_chk;
   int n_fail;
   int n;

   keypad_scanner #(
      .ROWS (4), .COLS (4), .SCAN_CYCLES (SC),
      .DEBOUNCE_CYCLES (D), .HEX_MAP (1)
   ) u_dut1 (
      .i_clk (clk), .i_rst_n (rst_n), .i_cols (cols1),
      .o_rows (rows1), .o_key_valid (valid1), .o_key_code (code1),
      .i_key_ready (ready1), .o_key_held (held1), .o_overflow (ovf1)
   );

   keypad_scanner #(
      .ROWS (2), .COLS (3), .SCAN_CYCLES (SC),
      .DEBOUNCE_CYCLES (D), .HEX_MAP (0)
   ) u_dut2 (
      .i_clk (clk), .i_rst_n (rst_n), .i_cols (cols2),
      .o_rows (rows2), .o_key_valid (valid2), .o_key_code (code2),
      .i_key_ready (ready2), .o_key_held (held2), .o_overflow (ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Physical keypad: a pressed key shorts its row line to its column
   always_comb begin
      cols1 = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (rows1[r] && press1[r*4+c]) cols1[c] = 1'b1;
   end

   always_comb begin
      cols2 = '0;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 3; c++)
            if (rows2[r] && press2[r*3+c]) cols2[c] = 1'b1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s n=%0d got=%0d exp=%0d", tag, n, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      n++;
   endtask

   task automatic check_reset_outs();
      chk("rst_rows1", int'(rows1), 1);
      chk("rst_valid1", int'(valid1), 0);
      chk("rst_code1", int'(code1), 0);
      chk("rst_held1", int'(held1), 0);
      chk("rst_ovf1", int'(ovf1), 0);
      chk("rst_rows2", int'(rows2), 1);
      chk("rst_valid2", int'(valid2), 0);
      chk("rst_held2", int'(held2), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
   endtask

   task automatic run_clean(input int r, input int c, input int hold);
      int s, e, rl, x, er;
      press1 = '0;
      press1[r*4+c] = 1'b1;
      ready1 = 1'b1;
      do_reset();
      s  = (r + 1) * SC;
      e  = s + D + 1;
      rl = e + hold;
      x  = rl + 4 + D;
      while (n < x + 2 * R * SC) begin
         tick();
         if (n == rl) press1 = '0;
         if (n < s) er = (n / SC) % R;
         else if (n < x) er = r;
         else er = (r + 1 + (n - x) / SC) % R;
         chk("clean_rows", int'(rows1), 1 << er);
         chk("clean_valid", int'(valid1), int'(n == e));
         if (n == e) chk("clean_code", int'(code1), HEXT[r*4+c]);
         chk("clean_held", int'(held1), int'(n >= e && n <= rl + 2 + D));
         chk("clean_ovf", int'(ovf1), 0);
      end
   endtask

   task automatic run_bounce(input int r, input int c);
      int s, ev;
      press1 = '0;
      press1[r*4+c] = 1'b1;
      ready1 = 1'b1;
      do_reset();
      s  = (r + 1) * SC;
      ev = 0;
      while (n < s + 200) begin
         tick();
         press1[r*4+c] = !(n >= s && n < s + 10 && ((n - s) / 2) % 2 == 0);
         if (n <= s + 12 + D) chk("bounce_quiet", int'(valid1), 0);
         if (valid1) begin
            ev++;
            chk("bounce_code", int'(code1), HEXT[r*4+c]);
         end
         chk("bounce_ovf", int'(ovf1), 0);
      end
      chk("bounce_events", ev, 1);
   endtask

   task automatic run_multi(input int r, input int c1, input int c2);
      press1 = '0;
      press1[r*4+c1] = 1'b1;
      press1[r*4+c2] = 1'b1;
      ready1 = 1'b1;
      do_reset();
      while (n < 3 * R * SC) begin
         tick();
         chk("multi_rows", int'(rows1), 1 << ((n / SC) % R));
         chk("multi_valid", int'(valid1), 0);
         chk("multi_held", int'(held1), 0);
      end
   endtask

   task automatic run_ovf(input int k1, input int k2, input int mode);
      int r1, r2, e1, rl, x, d, e2, tr, last;
      r1 = k1 / 4;
      r2 = k2 / 4;
      press1 = '0;
      press1[k1] = 1'b1;
      ready1 = 1'b0;
      do_reset();
      e1 = (r1 + 1) * SC + D + 1;
      rl = e1 + 5;
      x  = rl + 4 + D;
      d  = (r2 - r1 - 1 + 2 * R) % R;
      e2 = x + d * SC + SC + D + 1;
      tr = (mode != 0) ? e2 - 1 : e2 + 3;
      last = (mode != 0) ? e2 : e2 + 3;
      while (n < e2 + 3 * R * SC) begin
         tick();
         if (n == rl) begin
            press1[k1] = 1'b0;
            press1[k2] = 1'b1;
         end
         if (n == tr) ready1 = 1'b1;
         chk("ovf_valid", int'(valid1), int'(n >= e1 && n <= last));
         if (n >= e1 && n <= last)
            chk("ovf_code", int'(code1),
                (mode != 0 && n == e2) ? HEXT[k2] : HEXT[k1]);
         chk("ovf_pulse", int'(ovf1), int'(mode == 0 && n == e2));
         chk("ovf_held", int'(held1),
             int'((n >= e1 && n <= rl + 2 + D) || n >= e2));
      end
   endtask

   task automatic run_rst(input int r, input int c, input int mode);
      int s, at;
      press1 = '0;
      press1[r*4+c] = 1'b1;
      ready1 = (mode != 0) ? 1'b0 : 1'b1;
      do_reset();
      s  = (r + 1) * SC;
      at = (mode != 0) ? s + D + 4 : s + 3;
      while (n < at) tick();
      chk("pre_rst_held", int'(held1), int'(mode != 0));
      rst_n = 1'b0;
      #1;
      check_reset_outs();
      press1 = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (n < 3 * R * SC) begin
         tick();
         chk("rst_rows", int'(rows1), 1 << ((n / SC) % R));
         chk("rst_valid", int'(valid1), 0);
         chk("rst_held", int'(held1), 0);
      end
   endtask

   task automatic run_d2(input int r, input int c);
      int s, e, er;
      press2 = '0;
      press2[r*3+c] = 1'b1;
      ready2 = 1'b1;
      do_reset();
      s = (r + 1) * SC;
      e = s + D + 1;
      while (n < e + 20) begin
         tick();
         er = (n < s) ? (n / SC) % 2 : r;
         chk("d2_rows", int'(rows2), 1 << er);
         chk("d2_valid", int'(valid2), int'(n == e));
         if (n == e) chk("d2_code", int'(code2), r * 3 + c);
         chk("d2_held", int'(held2), int'(n >= e));
         chk("d2_ovf", int'(ovf2), 0);
      end
      press2 = '0;
   endtask

   initial begin
      int a, b, k;
      n_chk  = 0;
      n_fail = 0;
      n      = 0;
      rst_n  = 1'b0;
      press1 = '0;
      press2 = '0;
      ready1 = 1'b1;
      ready2 = 1'b1;

      run_clean(1, 2, 20);
      for (int i = 0; i < 5; i++)
         run_clean($urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 30));

      run_bounce(3, 1);
      run_bounce($urandom_range(0, 3), $urandom_range(0, 3));

      run_multi(0, 0, 3);
      a = $urandom_range(0, 3);
      b = (a + 1 + $urandom_range(0, 2)) % 4;
      run_multi($urandom_range(0, 3), a, b);

      run_ovf(5, 10, 0);
      for (int i = 0; i < 4; i++) begin
         k = $urandom_range(0, 15);
         run_ovf(k, (k + 1 + $urandom_range(0, 14)) % 16, i % 2);
      end

      run_rst(2, 1, 0);
      run_rst($urandom_range(0, 3), $urandom_range(0, 3), 1);

      run_d2(1, 2);
      run_d2($urandom_range(0, 1), $urandom_range(0, 2));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner: drives one keypad row at a time, synchronises and debounces the column returns, and emits one registered key event per debounced press through a valid/ready interface. It generalises our combinational row/column-to-digit decoder. Row count, column count, scan rate, debounce length and code mapping are configurable. It sits between the keypad pins and the display/digit-history logic.

## Interface
- ROWS, 4, number of keypad rows driven (2–8)
- COLS, 4, number of keypad columns sensed (2–8)
- SCAN_CYCLES, 4, clocks each row is driven per scan slot (≥3)
- DEBOUNCE_CYCLES, 8, consecutive identical samples needed to accept a press or a release (≥1)
- HEX_MAP, 1, when 1 (legal only for 4×4) the output is the hex digit; when 0 it is the raw index row*COLS+col
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- cols  input  COLS  raw column returns, active-high, asynchronous to clk
- rows  output  ROWS  row drive, one-hot, active-high
- key_valid  output  1  a key event is pending
- key_code  output  KW = max(4, $clog2(ROWS*COLS))  code of the pending event, stable while key_valid=1
- key_ready  input  1  consumer accepts the event when key_valid && key_ready
- key_held  output  1  a debounced key is currently down
- overflow  output  1  one-cycle pulse: a press was accepted while an event was still pending, and the new event was dropped

## Operation
- cols pass through a 2-flop synchroniser. All decisions use the synchronised value `cs`.
- The FSM has four states.
- SCAN: rows drives row r for SCAN_CYCLES clocks. `cs` is sampled on the last clock of the slot.
  - If exactly one column bit is set: latch (r, c), clear the counter and go to DEBOUNCE.
  - Otherwise (zero bits, or more than one): advance r, wrapping from ROWS-1 to 0.
- DEBOUNCE: row r stays driven. Each clock, `cs` is compared with the one-hot of c.
  - Match: counter increments.
  - Mismatch: return to SCAN on the same row with the slot counter cleared.
  - When the counter reaches DEBOUNCE_CYCLES: accept the key and go to HELD.
- HELD: key_held=1 and row r stays driven. Each clock in which `cs[c]`=0 increments the release counter; any clock with `cs[c]`=1 clears it. At DEBOUNCE_CYCLES, go to RELEASE.
- RELEASE: key_held=0. Advance r, wrapping as in SCAN, then go to SCAN.
- Other keys pressed during DEBOUNCE or HELD are ignored: only row r is driven, and in HELD only column c is examined.
- On accept:
  - If key_valid=0: load key_code and set key_valid.
  - If key_valid=1 (not being consumed in that same clock): keep the pending event and pulse overflow.
  - Accept and handshake in the same clock: the new event is loaded and no overflow is raised.
- key_valid clears on the clock after key_valid && key_ready, unless a new accept loads it in that clock.
- HEX_MAP=1 code table:
  - row0: 1, 2, 3, A
  - row1: 4, 5, 6, B
  - row2: 7, 8, 9, C
  - row3: E, 0, F, D
  - Columns are listed in order 0..3.
- Elaboration fails if HEX_MAP=1 and ROWS≠4 or COLS≠4.

## Timing
- Reset is asynchronous and active-low. Values while reset is asserted:
  - rows = 1 (row 0)
  - key_valid=0, key_code=0, key_held=0, overflow=0
  - FSM in SCAN; all counters and synchroniser flops 0
- Reset asserted mid-debounce or mid-hold discards the key. No event is emitted and no partial state survives.
- Synchroniser latency: 2 clocks.
- Worst-case scan period: ROWS*SCAN_CYCLES clocks.
- Press-to-event: from the sampling clock, key_valid rises DEBOUNCE_CYCLES+1 clocks later.
- Release-to-rescan: after key_held falls, rows advances on the next clock.
- A key held indefinitely produces exactly one event.
- rows changes only on clock edges and is always one-hot, including during reset.

## Structure
- Package keypad_pkg holds:
  - the FSM state enum (SCAN, DEBOUNCE, HELD, RELEASE)
  - the 4×4 hex code table as a constant array
  - the KW width function
- Sub-module sync_2ff (parameter WIDTH) is the column synchroniser, reusable by other asynchronous inputs.
- Everything else is one module.

## Test plan
Use defaults unless stated: ROWS=4, COLS=4, SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, HEX_MAP=1.
- Press row1/col2 cleanly, key_ready=1 → one key_valid pulse with key_code=6; key_held=1 until release plus 8 clocks; rows then advances to row2.
- Press row3/col1 with 3 bounces of 2 clocks each → exactly one event, key_code=0; no event while the bounces continue.
- Row0 col0 and col3 pressed together → no event; scanning continues through rows 0,1,2,3,0.
- key_ready=0: press 5 then 9 → key_code=5 stays pending and overflow pulses once at the 9 accept; raising key_ready then yields no second event.
- Assert reset 3 clocks into DEBOUNCE → rows=0001 and all outputs 0 immediately; no event after release of reset.
- ROWS=2, COLS=3, HEX_MAP=0: press row1/col2 → key_code=5; rows cycles 01,10 with period 8 clocks.
